button_conditioner: RTL and testbench
=====================================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL provide parameter DEBOUNCE_CYCLES, default 1000000, number of stable cycles required before the debounced level changes (10 ms at 100 MHz).
REQ-002 SHALL provide parameter HOLD_CYCLES, default 50000000, number of cycles after press_pulse until the first repeat_pulse (0.5 s).
REQ-003 SHALL provide parameter REPEAT_CYCLES, default 10000000, period of repeat_pulse while held (0.1 s).
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 button  input  1  raw asynchronous pushbutton, active-high.
REQ-007 btn_level  output  1  debounced button level.
REQ-008 press_pulse  output  1  one-cycle strobe on debounced rising edge.
REQ-009 release_pulse  output  1  one-cycle strobe on debounced falling edge.
REQ-010 repeat_pulse  output  1  one-cycle auto-repeat strobe while held.
REQ-011 held  output  1  high while in long-press (repeating) state.

Function
REQ-012 SHALL pass button through a two-flop synchronizer; only the second flop (sync) feeds downstream logic.
REQ-013 Debounce counter SHALL increment on every edge where sync differs from btn_level and clear to 0 on every edge where they match.
REQ-014 On an edge where the counter equals DEBOUNCE_CYCLES-1 and sync still differs, btn_level SHALL toggle and the counter SHALL clear.
REQ-015 Latency: button changed and stable before edge N -> btn_level changes at edge N+1+DEBOUNCE_CYCLES.
REQ-016 A raw pulse or glitch shorter than DEBOUNCE_CYCLES cycles (at sync) SHALL NOT change btn_level or produce any strobe.
REQ-017 press_pulse SHALL be high exactly the first cycle btn_level is 1; release_pulse exactly the first cycle btn_level is 0; all strobes registered.
REQ-018 Hold FSM states: RELEASED, HOLD_WAIT, REPEATING; all counters at least 26 bits, no wrap within parameter range.
REQ-019 RELEASED -> HOLD_WAIT on the edge btn_level rises; hold counter cleared to 0.
REQ-020 HOLD_WAIT: hold counter increments each cycle; on the edge where it equals HOLD_CYCLES-1 -> REPEATING, repeat_pulse high and held high the following cycle; first repeat_pulse occurs exactly HOLD_CYCLES cycles after press_pulse.
REQ-021 REPEATING: repeat counter clears on entry, increments each cycle; each time it reaches REPEAT_CYCLES-1 it clears and repeat_pulse is high the next cycle; period exactly REPEAT_CYCLES.
REQ-022 From any state, debounced fall -> RELEASED on the same edge; held drops with release_pulse; counters clear.
REQ-023 Simultaneous release and repeat/hold expiry: release wins; no repeat_pulse, held not asserted in that cycle.
REQ-024 press_pulse and repeat_pulse SHALL never be high in the same cycle; repeat_pulse never high while btn_level is 0.

Reset
REQ-025 While reset is high at an edge: synchronizer flops, btn_level, all strobes, held = 0; state RELEASED; all counters 0.
REQ-026 Reset mid-operation aborts any debounce or hold in progress; a button still pressed after reset deasserts SHALL yield a fresh press_pulse after the full debounce latency.

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3)
REQ-027 Reset 5 cycles, button=0 -> all outputs 0 throughout and after.
REQ-028 button 0->1 before edge 10, held 1 -> btn_level and press_pulse high after edge 15; press_pulse high one cycle only.
REQ-029 button high 3 cycles then low (glitch) -> btn_level stays 0, no strobes.
REQ-030 Press held 30 cycles after press_pulse at cycle P -> repeat_pulse at P+10, P+13, P+16, ...; held high from P+10; release gives release_pulse, held 0, no further repeats.
REQ-031 Release timed so debounced fall coincides with a repeat slot -> release_pulse only, no repeat_pulse.
REQ-032 Reset asserted during REPEATING with button held, then deasserted -> outputs 0 during reset; press_pulse 5 cycles after reset drops (2 sync + debounce), hold sequence restarts.

Source files
------------

// File: rtl/button_conditioner.sv
// Pushbutton conditioner: synchronizer, debouncer, edge strobes and
// long-press auto-repeat with registered one-cycle strobes.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned HOLD_CYCLES     = 50000000,
  parameter int unsigned REPEAT_CYCLES   = 10000000
) (
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse,
  output logic held
);

  typedef enum logic [1:0] {
    RELEASED,
    HOLD_WAIT,
    REPEATING
  } state_e;

  localparam logic [31:0] DEB_LAST  = DEBOUNCE_CYCLES - 1;
  localparam logic [31:0] HOLD_LAST = HOLD_CYCLES - 1;
  localparam logic [31:0] REP_LAST  = REPEAT_CYCLES - 1;

  logic        sync1_q, sync_q, level_q;
  logic        press_q, release_q, repeat_q, held_q;
  logic        repeat_d, held_d;
  logic [31:0] deb_cnt_q, deb_cnt_d;
  logic [31:0] hold_cnt_q, hold_cnt_d;
  logic [31:0] rep_cnt_q, rep_cnt_d;
  state_e      state_q, state_d;
  logic        differ, deb_done, rise, fall;
  logic        hold_exp, rep_exp;

  always_comb begin
    differ    = sync_q ^ level_q;
    deb_done  = differ && (deb_cnt_q == DEB_LAST);
    rise      = deb_done && !level_q;
    fall      = deb_done && level_q;
    deb_cnt_d = (differ && !deb_done) ? deb_cnt_q + 32'd1 : '0;
    hold_exp  = (hold_cnt_q == HOLD_LAST);
    rep_exp   = (rep_cnt_q == REP_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= 1'b0;
      sync_q     <= 1'b0;
      level_q    <= 1'b0;
      deb_cnt_q  <= '0;
      state_q    <= RELEASED;
      hold_cnt_q <= '0;
      rep_cnt_q  <= '0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      repeat_q   <= 1'b0;
      held_q     <= 1'b0;
    end else begin
      sync1_q    <= button;
      sync_q     <= sync1_q;
      level_q    <= level_q ^ deb_done;
      deb_cnt_q  <= deb_cnt_d;
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      rep_cnt_q  <= rep_cnt_d;
      press_q    <= rise;
      release_q  <= fall;
      repeat_q   <= repeat_d;
      held_q     <= held_d;
    end
  end

  // A debounced fall takes priority over any hold/repeat expiry.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = '0;
    rep_cnt_d  = '0;
    unique case (state_q)
      RELEASED: begin
        if (rise) state_d = HOLD_WAIT;
      end
      HOLD_WAIT: begin
        if (fall) state_d = RELEASED;
        else if (hold_exp) state_d = REPEATING;
        else hold_cnt_d = hold_cnt_q + 32'd1;
      end
      REPEATING: begin
        if (fall) state_d = RELEASED;
        else if (!rep_exp) rep_cnt_d = rep_cnt_q + 32'd1;
      end
      default: state_d = RELEASED;
    endcase
  end

  always_comb begin
    repeat_d = !fall &&
      ((state_q == HOLD_WAIT && hold_exp) ||
       (state_q == REPEATING && rep_exp));
    held_d   = (state_d == REPEATING);
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign repeat_pulse  = repeat_q;
  assign held          = held_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with small debounce/hold/repeat
// parameters; outputs packed {level,press,release,repeat,held}.
module tb_button_conditioner;

  logic clk = 1'b0;
  logic reset, button;
  logic btn_level, press_pulse, release_pulse, repeat_pulse, held;

  int n_cmp = 0;
  int n_bad = 0;

  button_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES(10),
    .REPEAT_CYCLES(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .button(button),
    .btn_level(btn_level),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .repeat_pulse(repeat_pulse),
    .held(held)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       btn;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(int n, logic b, logic r, logic [4:0] e);
    vec_t v;
    v.rst = r;
    v.btn = b;
    v.exp = e;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endfunction

  function automatic logic [4:0] outs();
    return {btn_level, press_pulse, release_pulse, repeat_pulse, held};
  endfunction

  task automatic step(input logic r, input logic b);
    reset  = r;
    button = b;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int idx,
                       input logic [4:0] exp);
    n_cmp++;
    if (outs() !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got lvl/pr/rl/rp/hd=%b, want %b",
               name, idx, outs(), exp);
    end
  endtask

  initial begin
    logic [4:0] e;
    reset  = 1'b1;
    button = 1'b0;

    // Reset, press, auto-repeat, normal release, then a short glitch.
    add(5, 0, 1, 5'b00000);
    add(4, 0, 0, 5'b00000);
    add(5, 1, 0, 5'b00000);
    add(1, 1, 0, 5'b11000);
    add(9, 1, 0, 5'b10000);
    add(1, 1, 0, 5'b10011);
    for (int k = 0; k < 6; k++) begin
      add(2, 1, 0, 5'b10001);
      add(1, 1, 0, 5'b10011);
    end
    add(2, 1, 0, 5'b10001);
    add(1, 0, 0, 5'b10011);
    add(2, 0, 0, 5'b10001);
    add(1, 0, 0, 5'b10011);
    add(1, 0, 0, 5'b10001);
    add(1, 0, 0, 5'b00100);
    add(5, 0, 0, 5'b00000);
    add(3, 1, 0, 5'b00000);
    add(8, 0, 0, 5'b00000);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].btn);
      check("table", i, vecs[i].exp);
    end

    // Debounced fall lands exactly on a repeat slot: release only.
    for (int i = 0; i < 30; i++) begin
      step(1'b0, i < 16);
      e[4] = (i >= 5 && i < 21);
      e[3] = (i == 5);
      e[2] = (i == 21);
      e[1] = (i == 15 || i == 18);
      e[0] = (i >= 15 && i < 21);
      check("rel_on_slot", i, e);
    end

    // Reset during REPEATING with the button still held.
    for (int i = 0; i < 41; i++) begin
      step(i >= 18 && i <= 20, 1'b1);
      e[4] = (i >= 5 && i < 18) || (i >= 26);
      e[3] = (i == 5 || i == 26);
      e[2] = 1'b0;
      e[1] = (i == 15 || i == 36 || i == 39);
      e[0] = (i >= 15 && i < 18) || (i >= 36);
      check("mid_reset", i, e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
